fixed_mult_seq: RTL

- Iterative, handshaked, parametrised successor to the combinational fixed-point multiplier.
- Operands and result are sign-magnitude Q(M.N) words: MSB is the sign, the lower N+M bits are the magnitude (M integer bits, N fraction bits).
- Multiplies by shift-and-add, one magnitude bit per clock, so wide formats fit without a full-width array multiplier.
- Adds selectable rounding, saturation or wrap on overflow, an overflow flag, and valid/ready flow control on both sides.
- Sits between the fixed-point datapath stages that already use ready/valid.

---
 rtl/fixed_mult_seq_if.sv | 25 ++
 rtl/fixed_mult_seq.sv | 123 ++++++++++++
 2 files changed

// File: rtl/fixed_mult_seq_if.sv
// Ready/valid bundle for the sequential sign-magnitude fixed-point multiplier.
// The master side supplies operands and consumes results; the slave side is the multiplier.
interface fixed_mult_seq_if #(
   parameter int W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         rnd_mode;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out;
   logic         ovf;

   modport master (
      output in_valid, a, b, rnd_mode, out_ready,
      input  in_ready, out_valid, out, ovf
   );

   modport slave (
      input  in_valid, a, b, rnd_mode, out_ready,
      output in_ready, out_valid, out, ovf
   );
endinterface

// File: rtl/fixed_mult_seq.sv
// Iterative shift-and-add multiplier for sign-magnitude Q(M.N) words, one magnitude bit per clock,
// with truncate/round-half-away selection and saturate-or-wrap overflow handling.
module fixed_mult_seq #(
   parameter int N   = 23,
   parameter int M   = 8,
   parameter int SAT = 1
) (
   input logic             clk,
   input logic             rst,
   fixed_mult_seq_if.slave bus
);
   localparam int W  = N + M + 1;
   localparam int MW = N + M;
   localparam int CW = $clog2(MW + 1);

   typedef enum logic [1:0] {IDLE, MUL, RND, DONE} state_t;

   state_t          state_q, state_d;
   logic [2*MW-1:0] mcand_q, mcand_d;
   logic [MW-1:0]   mplier_q, mplier_d;
   logic [2*MW-1:0] acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            sign_q, sign_d;
   logic            rnd_q, rnd_d;
   logic [W-1:0]    out_q, out_d;
   logic            ovf_q, ovf_d;

   logic [MW:0]     k_rnd;
   logic            ovf_res;
   logic [MW-1:0]   mag;
   logic            res_sign;
   logic            unused_lsbs;

   // Product bits below the rounding position never influence the result.
   assign unused_lsbs = ^acc_q[N-2:0];

   always_comb begin
      k_rnd    = {1'b0, acc_q[2*N+M-1:N]} + {{MW{1'b0}}, rnd_q & acc_q[N-1]};
      ovf_res  = (|acc_q[2*MW-1:2*N+M]) | k_rnd[MW];
      mag      = k_rnd[MW-1:0];
      if (ovf_res && SAT != 0) begin
         mag = '1;
      end
      res_sign = sign_q & (|mag);
   end

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      sign_d   = sign_q;
      rnd_d    = rnd_q;
      out_d    = out_q;
      ovf_d    = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               mcand_d  = {{MW{1'b0}}, bus.a[MW-1:0]};
               mplier_d = bus.b[MW-1:0];
               sign_d   = bus.a[W-1] ^ bus.b[W-1];
               rnd_d    = bus.rnd_mode;
               acc_d    = '0;
               cnt_d    = CW'(MW);
               state_d  = MUL;
            end
         end
         MUL: begin
            // The multiplicand is pre-shifted each cycle, so it always sits at the iteration index.
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = {mcand_q[2*MW-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[MW-1:1]};
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = RND;
            end
         end
         RND: begin
            out_d   = {res_sign, mag};
            ovf_d   = ovf_res;
            state_d = DONE;
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         sign_q   <= 1'b0;
         rnd_q    <= 1'b0;
         out_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         sign_q   <= sign_d;
         rnd_q    <= rnd_d;
         out_q    <= out_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out       = out_q;
   assign bus.ovf       = ovf_q;
endmodule
